uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 CLK  input  1  TX bit clock; one serial bit period equals one CLK cycle.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel word to transmit; sampled only on the accept edge.
REQ-005 DATA_VALID  input  1  request to send P_DATA; honoured only while the FSM is in IDLE.
REQ-006 PAR_EN  input  1  1 = parity bit inserted; sampled on the accept edge.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on the accept edge.
REQ-008 TX_OUT  output  1  serial line, registered; idles high.
REQ-009 Busy  output  1  registered; high from the start bit through the stop bit.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-011 The accept edge is the rising CLK edge where state = IDLE and DATA_VALID = 1; at that edge the block SHALL latch P_DATA, PAR_EN and PAR_TYP and go to START.
REQ-012 While not in IDLE, DATA_VALID and changes on P_DATA, PAR_EN and PAR_TYP SHALL be ignored, with no queuing.
REQ-013 START SHALL last one cycle with TX_OUT = 0.
REQ-014 DATA SHALL last DATA_WIDTH cycles, sending latched bits LSB first, one bit per cycle.
REQ-015 A bit counter of width clog2(DATA_WIDTH) SHALL count 0 to DATA_WIDTH-1 in DATA and clear on leaving DATA.
REQ-016 After DATA, the FSM SHALL go to PARITY if the latched PAR_EN = 1, otherwise to STOP.
REQ-017 PARITY SHALL last one cycle with TX_OUT = XOR of the latched data bits XOR the latched PAR_TYP.
REQ-018 STOP SHALL last one cycle with TX_OUT = 1, then go to IDLE unconditionally.
REQ-019 TX_OUT SHALL be 1 in IDLE.
REQ-020 Timing: TX_OUT drives the start bit in the cycle after the accept edge; frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
REQ-021 Busy SHALL be 1 exactly while in START, DATA, PARITY or STOP, and 0 in IDLE.
REQ-022 Minimum spacing between accept edges SHALL be frame length + 1 cycle; DATA_VALID held high continuously yields frames separated by one idle-high cycle.
REQ-023 TX_OUT and Busy SHALL come from flops, with no combinational path from any input to an output.

Reset
REQ-024 When RST = 0, the block SHALL immediately (asynchronously) force state = IDLE, TX_OUT = 1, Busy = 0, and clear the data register, parity configuration and bit counter to 0.
REQ-025 A reset mid-frame SHALL abort the frame with no stop bit; the first accept after RST deasserts SHALL start a fresh, complete frame.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encoding (3-bit) and the constants PAR_EVEN = 0 and PAR_ODD = 1.
REQ-027 The load/shift datapath SHALL be a sub-module uart_tx_serializer providing:
- load on accept;
- shift-right enable in DATA;
- serial output from bit 0;
- a combinational parity output over the loaded word.
REQ-028 The FSM, bit counter and output mux SHALL reside in uart_tx.

Verification
REQ-029 P_DATA = 0xA5, PAR_EN = 0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, Busy high exactly those 10 cycles.
REQ-030 P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0 -> parity bit 0 in cycle 10, stop bit in cycle 11; with PAR_TYP = 1 -> parity bit 1.
REQ-031 P_DATA = 0x00, PAR_EN = 1, PAR_TYP = 1 -> data bits all 0, parity bit 1, stop bit 1.
REQ-032 DATA_VALID with 0x3C while Busy, then P_DATA changed to 0xFF mid-frame -> current frame unaltered, 0x3C never sent.
REQ-033 DATA_VALID held high with 0x55 then 0x0F -> two frames separated by exactly one idle cycle with TX_OUT = 1.
REQ-034 RST asserted during the 4th data bit -> TX_OUT = 1 and Busy = 0 at once; a new accept of 0x81 yields a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-type constants and the parity-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity reproduces the data XOR; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift datapath for the transmitter. The loaded word is held unshifted
// so its parity remains available after every data bit has been sent.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_out,
    output logic                  parity
);

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    // Next-state: a load takes priority over shifting.
    always_comb begin
        word_d  = word_q;
        shift_d = shift_q;
        if (load) begin
            word_d  = data_in;
            shift_d = data_in;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
        end
    end

    // Word and shift registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            shift_q <= '0;
        end else begin
            word_q  <= word_d;
            shift_q <= shift_d;
        end
    end

    assign ser_out = shift_q[0];
    assign parity  = ^word_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per CLK cycle, optional parity bit.
//
//   state  | meaning
//   IDLE   | line high, waiting for DATA_VALID
//   START  | start bit (0)
//   DATA   | DATA_WIDTH data bits, LSB first
//   PARITY | parity bit (only when PAR_EN was latched high)
//   STOP   | stop bit (1), then back to IDLE
//
// Outputs are registered from the next state so TX_OUT shows the start bit
// in the cycle right after the accept edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             load, shift_en;
    logic             ser_out, ser_parity;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (P_DATA),
        .ser_out  (ser_out),
        .parity   (ser_parity)
    );

    // Next-state, bit counter and output mux, driven from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    load      = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    state_d   = START;
                end
            end
            START:  state_d = DATA;
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: state_d = STOP;
            STOP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shifting on every edge into DATA keeps the next bit at position 0.
        shift_en = (state_d == DATA);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_out;
            PARITY:  tx_d = parity_bit(ser_parity, par_typ_q);
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state, counter, latched configuration and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
